// File: rtl/counter_mod_updown.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_mod_updown: modulo-limit up/down counter, clear/load, one-shot.    |
// | Rev 1.0. Define COUNTER_PRESCALE_EN for a PRESCALE-cycle step divider.     |
// +----------------------------------------------------------------------------+
module counter_mod_updown #(
  parameter int BITS     = 4,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            up,
  input  logic            oneshot,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic [BITS-1:0] limit,
  output logic [BITS-1:0] q,
  output logic            tick,
  output logic            done,
  output logic            running
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("counter_mod_updown: PRESCALE out of range");
  end

  logic [0:0]      state_q, state_d;
  logic [BITS-1:0] count_q, count_d;
  logic            step_strobe;
  logic            step;
  logic            terminal;
  logic            run_en;

  assign run_en = (state_q == ST_RUN) && en;

`ifdef COUNTER_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc_q, presc_d;

  assign step_strobe = (presc_q == PS_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr || load) begin
      presc_d = '0;
    end else if (run_en) begin
      presc_d = step_strobe ? '0 : presc_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step_strobe = 1'b1;
`endif

  // >= in the up direction keeps a runtime limit drop below q from running away.
  assign terminal = up ? (count_q >= limit) : (count_q == '0);
  assign step     = run_en && step_strobe;
  assign tick     = step && terminal;

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (clr) begin
      count_d = '0;
      state_d = ST_RUN;
    end else if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
      state_d = ST_RUN;
    end else if (step) begin
      if (terminal && oneshot) begin
        state_d = ST_HALT;
      end else if (up) begin
        count_d = terminal ? '0 : count_q + BITS'(1);
      end else begin
        count_d = terminal ? limit : count_q - BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign q       = count_q;
  assign done    = (state_q == ST_HALT);
  assign running = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_updown.sv
`default_nettype none
// Directed, table-driven check of counter_mod_updown (BITS=4).
module tb_counter_mod_updown;

`ifdef COUNTER_PRESCALE_EN
  localparam int TB_PS = 3;
`else
  localparam int TB_PS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, clr, en, up, oneshot, load;
  logic [3:0] load_val, limit;
  logic [3:0] q;
  logic       tick, done, running;

  int n_checks = 0;
  int n_fail   = 0;

  counter_mod_updown #(.BITS(4), .PRESCALE(TB_PS)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .oneshot(oneshot),
    .load(load), .load_val(load_val), .limit(limit),
    .q(q), .tick(tick), .done(done), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, load, en, up, oneshot;
    logic [3:0] load_val, limit;
    logic [3:0] exp_q;
    logic       exp_tick, exp_done, exp_running;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic l, input logic e,
                              input logic u, input logic o,
                              input logic [3:0] lv, input logic [3:0] lim,
                              input logic [3:0] eq, input logic et,
                              input logic ed, input logic er);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.oneshot = o;
    v.load_val = lv; v.limit = lim;
    v.exp_q = eq; v.exp_tick = et; v.exp_done = ed; v.exp_running = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0; load = 1'b0;
    load_val = 4'd0; limit = 4'd9;

`ifdef COUNTER_PRESCALE_EN
    for (int i = 0; i < 10; i++)
      add(0, 0, 1, 1, 0, 0, 2, 4'(i / 3 < 3 ? i / 3 : 0), (i == 8), 0, 1);
    add(0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 2, 1, 0, 0, 1);
`else
    // Free-running up count, limit 9.
    for (int i = 0; i < 12; i++)
      add(0, 0, 1, 1, 0, 0, 9, 4'(i % 10), (i == 9), 0, 1);
    // Load 3 then count down modulo 5.
    add(0, 1, 0, 0, 0, 3, 5, 2, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 5, 3, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 5, 2, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 5, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 5, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 5, 5, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 5, 4, 0, 0, 1);
    // One-shot up to 3, halt, then leave HALT by load.
    add(1, 0, 0, 1, 1, 0, 3, 3, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 3, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 3, 1, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 3, 2, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 3, 3, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0, 3, 3, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 3, 3, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 3, 3, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 1);
    // clr beats load; load above limit clamps.
    add(0, 1, 0, 1, 0, 6, 9, 1, 0, 0, 1);
    add(1, 1, 0, 1, 0, 6, 9, 6, 0, 0, 1);
    add(0, 1, 0, 1, 0, 12, 9, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 9, 9, 0, 0, 1);
    // Limit lowered below q while counting up.
    add(0, 1, 0, 1, 0, 7, 9, 9, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 4, 7, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 1);
`endif

    #12;
    chk("reset_q", -1, 32'(q), 0);
    chk("reset_tick", -1, 32'(tick), 0);
    chk("reset_done", -1, 32'(done), 0);
    chk("reset_running", -1, 32'(running), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en; up = vecs[i].up;
      oneshot = vecs[i].oneshot; load_val = vecs[i].load_val; limit = vecs[i].limit;
      #2;
      chk("q", i, 32'(q), 32'(vecs[i].exp_q));
      chk("tick", i, 32'(tick), 32'(vecs[i].exp_tick));
      chk("done", i, 32'(done), 32'(vecs[i].exp_done));
      chk("running", i, 32'(running), 32'(vecs[i].exp_running));
      @(posedge clk); #1;
    end

`ifndef COUNTER_PRESCALE_EN
    // Asynchronous reset mid-cycle at q=5.
    clr = 0; en = 0; up = 1; oneshot = 0; load = 1; load_val = 4'd5; limit = 4'd9;
    @(posedge clk); #1;
    load = 0;
    #1;
    chk("preload_q", 0, 32'(q), 5);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_q", 0, 32'(q), 0);
    chk("async_rst_running", 0, 32'(running), 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // limit=0 holds q at 0 with tick on every step, both directions.
    limit = 4'd0; en = 1; up = 1;
    #2;
    chk("lim0_up_q", 0, 32'(q), 0);
    chk("lim0_up_tick", 0, 32'(tick), 1);
    @(posedge clk); #1;
    up = 0;
    #2;
    chk("lim0_dn_q", 0, 32'(q), 0);
    chk("lim0_dn_tick", 0, 32'(tick), 1);
    @(posedge clk); #1;
    #1;
    chk("lim0_hold_q", 0, 32'(q), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
Parametrised successor to the free-running power-of-two counter. Counts up or down modulo a runtime limit, with enable, synchronous clear, parallel load, and a one-shot mode that halts at terminal count. Serves as the shared timebase and event-counting primitive for timers, baud generators and display scanners.

Parameters:
BITS, 4, counter width; q, limit and load_val are BITS wide.
PRESCALE, 1, enabled cycles per count step; used only when COUNTER_PRESCALE_EN is defined; legal values are 1 to 2**16-1.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-high.
clr  input  1  synchronous clear.
en  input  1  count enable.
up  input  1  direction; 1 counts up, 0 counts down.
oneshot  input  1  mode; 1 selects one-shot, 0 selects free-running.
load  input  1  synchronous parallel load.
load_val  input  BITS  load value.
limit  input  BITS  terminal value; count range is 0..limit.
q  output  BITS  current count.
tick  output  1  terminal-count strobe.
done  output  1  high while the one-shot has finished (HALT state).
running  output  1  high while in RUN state.

Behaviour:
- Reset (rst=1), asynchronous: q=0, state=RUN, done=0, running=1, tick=0, prescaler cleared.
- States:
  - RUN: counts.
  - HALT: holds q; en, up and oneshot are ignored.
- Priority per clock edge: rst > clr > load > count step.
- clr: q<=0, state<=RUN.
- load: q<=min(load_val, limit), state<=RUN. Values above limit are clamped.
- Step condition: state==RUN && en (ANDed with the prescaler strobe when the feature is enabled).
- Terminal condition:
  - up=1: q>=limit. Using >= makes a runtime lowering of limit below q safe.
  - up=0: q==0.
- tick: combinational, equal to step condition && terminal condition. Zero latency: it is high in the same cycle that q shows the terminal value.
- Up step: q<=0 if terminal, else q+1.
- Down step: q<=limit if terminal, else q-1.
- One-shot mode: on a step at terminal, q holds (no wrap), state<=HALT, and done=1 from the next cycle. HALT is left only via clr or load.
- Clearing oneshot while in HALT does not resume counting.
- limit=0: up and down both hold q=0, and tick is high on every step cycle.
- All arithmetic is BITS wide unsigned. No overflow is possible because the wrap is explicit.
- Changing up mid-count takes effect on the next step. No extra cycle is inserted.
- done and running are registered, decoded directly from state, and never both high.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - An internal ceil(log2(PRESCALE))-bit prescaler increments on each cycle where state==RUN && en.
  - The strobe is high when the prescaler equals PRESCALE-1; the prescaler wraps to 0 on the strobe.
  - The count step and tick are additionally qualified by the strobe.
  - rst, clr and load clear the prescaler.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic is generated; PRESCALE is ignored and steps occur on every enabled RUN cycle.

Test Plan:
1. BITS=4, limit=9, up=1, en=1 from reset -> q runs 0..9 then 0, period 10; tick high only while q=9; done=0 throughout.
2. up=0, limit=5, load_val=3 pulsed, then en=1 -> q=3,2,1,0,5,4; tick high only at q=0.
3. oneshot=1, up=1, limit=3 -> q=0,1,2,3 then holds at 3; done=1 and running=0 from the cycle after tick; further en gives no change; a load with load_val=1 gives q=1, running=1.
4. clr=1 and load=1 in the same cycle with q=6 -> q=0. Then load=1 with load_val=12 and limit=9 -> q=9 (clamped).
5. Counting up with q=7, limit changed to 4 -> tick high while q=7, next q=0. Separately, rst pulsed asynchronously mid-cycle at q=5 -> q=0 before the next clock edge.
6. With COUNTER_PRESCALE_EN and PRESCALE=3, limit=2, en=1 -> q advances once every 3 cycles (0,0,0,1,1,1,2,...); tick is a 1-cycle pulse on the strobe cycle at q=2; dropping en freezes both q and the prescaler.
